// File: rtl/truth_table_sweeper.sv
// Sweeps all 16 input vectors through the external boolean evaluator, samples
// its output after a programmable settle time and grades the measured table.
module truth_table_sweeper #(
  parameter int          SETTLE_CYCLES = 1,
  parameter logic [15:0] EXPECTED      = 16'hD0D0
) (
  input  logic        clkWire,
  input  logic        rstWire,
  input  logic        startWire,
  input  logic        yWire,
  output logic        aWire,
  output logic        bWire,
  output logic        cWire,
  output logic        dWire,
  output logic        busyWire,
  output logic        doneWire,
  output logic        passWire,
  output logic [15:0] resultWire,
  output logic [4:0]  failCountWire,
  output logic [3:0]  failIndexWire
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} stateT;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  stateT      state;
  stateT      nextState;
  logic [3:0] idx;
  logic [3:0] settleCnt;

  always_ff @(posedge clkWire or posedge rstWire) begin
    if (rstWire) state <= IDLE;
    else         state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (startWire) nextState = SETTLE;
      SETTLE:  if (settleCnt <= 4'd1) nextState = SAMPLE;
      SAMPLE:  nextState = (idx == 4'd15) ? DONE : SETTLE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // idx doubles as the registered evaluator vector; it is parked at 0 outside a sweep
  always_ff @(posedge clkWire or posedge rstWire) begin
    if (rstWire) begin
      idx           <= 4'd0;
      settleCnt     <= 4'd0;
      resultWire    <= 16'd0;
      failCountWire <= 5'd0;
      failIndexWire <= 4'd0;
      passWire      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (startWire) begin
            resultWire    <= 16'd0;
            failCountWire <= 5'd0;
            failIndexWire <= 4'd0;
            passWire      <= 1'b0;
            idx           <= 4'd0;
            settleCnt     <= SETTLE_LOAD;
          end
        end
        SETTLE: begin
          if (settleCnt != 4'd0) settleCnt <= settleCnt - 4'd1;
        end
        SAMPLE: begin
          resultWire[idx] <= yWire;
          if (yWire != EXPECTED[idx]) begin
            failCountWire <= failCountWire + 5'd1;
            if (failCountWire == 5'd0) failIndexWire <= idx;
          end
          idx       <= (idx == 4'd15) ? 4'd0 : idx + 4'd1;
          settleCnt <= SETTLE_LOAD;
        end
        DONE: begin
          passWire <= (failCountWire == 5'd0);
        end
        default: begin
          idx <= 4'd0;
        end
      endcase
    end
  end

  assign {aWire, bWire, cWire, dWire} = idx;
  assign busyWire = (state != IDLE);
  assign doneWire = (state == DONE);

endmodule
